// File: rtl/pio_pkg.sv
// Shared definitions for the PIO pin output arbitration slice: default sizes,
// reassignment state encoding and the flat strobe-vector index helper.
package pio_pkg;

  localparam int NUM_PINS_DEFAULT  = 32;
  localparam int NUM_CORES_DEFAULT = 4;
  localparam int NUM_FSMS_DEFAULT  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    COMMIT = 2'd2
  } reassign_state_e;

  // Bit position of core c / fsm f / pin p inside the flattened strobe buses.
  function automatic int fsm_bit_idx(input int c, input int f, input int p,
                                     input int num_fsms = NUM_FSMS_DEFAULT,
                                     input int num_pins = NUM_PINS_DEFAULT);
    return ((c * num_fsms) + f) * num_pins + p;
  endfunction

endpackage

// File: rtl/core_pin_latch.sv
// Per-core pin value/direction latches; the lowest-index FSM strobing a pin
// wins, and out/dir strobes are resolved independently of each other.
module core_pin_latch
  import pio_pkg::*;
#(
  parameter int NUM_PINS = NUM_PINS_DEFAULT,
  parameter int NUM_FSMS = NUM_FSMS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FSMS*NUM_PINS-1:0] out_we,
  input  logic [NUM_FSMS*NUM_PINS-1:0] out_val,
  input  logic [NUM_FSMS*NUM_PINS-1:0] dir_we,
  input  logic [NUM_FSMS*NUM_PINS-1:0] dir_val,
  output logic [NUM_PINS-1:0]          out_next,
  output logic [NUM_PINS-1:0]          dir_next
);

  logic [NUM_PINS-1:0] out_latch_r;
  logic [NUM_PINS-1:0] dir_latch_r;

  // Walking from the highest FSM down lets the lowest strobing index win.
  always_comb begin
    out_next = out_latch_r;
    dir_next = dir_latch_r;
    for (int p = 0; p < NUM_PINS; p++) begin
      for (int f = NUM_FSMS - 1; f >= 0; f--) begin
        out_next[p] = out_we[fsm_bit_idx(0, f, p, NUM_FSMS, NUM_PINS)] ?
                      out_val[fsm_bit_idx(0, f, p, NUM_FSMS, NUM_PINS)] : out_next[p];
        dir_next[p] = dir_we[fsm_bit_idx(0, f, p, NUM_FSMS, NUM_PINS)] ?
                      dir_val[fsm_bit_idx(0, f, p, NUM_FSMS, NUM_PINS)] : dir_next[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_latch_r <= '0;
      dir_latch_r <= '0;
    end else begin
      out_latch_r <= out_next;
      dir_latch_r <= dir_next;
    end
  end

endmodule

// File: rtl/pin_output_arbiter.sv
// Routes each pin's latched value/direction from its owning core to registered
// pads, with break-before-make reassignment of pin ownership at runtime.
module pin_output_arbiter
  import pio_pkg::*;
#(
  parameter int NUM_PINS     = NUM_PINS_DEFAULT,
  parameter int NUM_CORES    = NUM_CORES_DEFAULT,
  parameter int NUM_FSMS     = NUM_FSMS_DEFAULT,
  parameter int BREAK_CYCLES = 1,
  parameter int SEL_W        = $clog2(NUM_CORES),
  parameter int PIN_W        = $clog2(NUM_PINS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_out_we,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_out_val,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_dir_we,
  input  logic [NUM_CORES*NUM_FSMS*NUM_PINS-1:0] fsm_dir_val,
  input  logic                                cfg_we,
  input  logic [PIN_W-1:0]                    cfg_pin,
  input  logic [SEL_W-1:0]                    cfg_core,
  output logic                                cfg_ready,
  output logic [NUM_PINS*SEL_W-1:0]           pin_core,
  output logic [NUM_PINS-1:0]                 gpio_output,
  output logic [NUM_PINS-1:0]                 gpio_drive
);

  localparam int LANE_W = NUM_FSMS * NUM_PINS;
  localparam int CNT_W  = $clog2(BREAK_CYCLES + 1);

  logic [NUM_PINS-1:0]             out_next_s [NUM_CORES];
  logic [NUM_PINS-1:0]             dir_next_s [NUM_CORES];

  reassign_state_e                 state_r, state_next_s;
  logic [CNT_W-1:0]                cnt_r, cnt_next_s;
  logic [PIN_W-1:0]                pin_r, pin_next_s;
  logic [SEL_W-1:0]                core_r, core_next_s;
  logic [NUM_PINS-1:0][SEL_W-1:0]  pin_core_r;
  logic                            cfg_ready_r;
  logic [NUM_PINS-1:0]             gpio_output_r, gpio_drive_r;
  logic [NUM_PINS-1:0]             gpio_output_next_s, gpio_drive_next_s;
  logic                            cfg_valid_s;
  logic [SEL_W-1:0]                cur_core_s;
  logic [SEL_W-1:0]                sel_s;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    core_pin_latch #(
      .NUM_PINS (NUM_PINS),
      .NUM_FSMS (NUM_FSMS)
    ) u_latch (
      .clk      (clk),
      .rst      (rst),
      .out_we   (fsm_out_we [fsm_bit_idx(c, 0, 0, NUM_FSMS, NUM_PINS) +: LANE_W]),
      .out_val  (fsm_out_val[fsm_bit_idx(c, 0, 0, NUM_FSMS, NUM_PINS) +: LANE_W]),
      .dir_we   (fsm_dir_we [fsm_bit_idx(c, 0, 0, NUM_FSMS, NUM_PINS) +: LANE_W]),
      .dir_val  (fsm_dir_val[fsm_bit_idx(c, 0, 0, NUM_FSMS, NUM_PINS) +: LANE_W]),
      .out_next (out_next_s[c]),
      .dir_next (dir_next_s[c])
    );
  end

  // Out-of-range pin or core indices only exist for non-power-of-two sizes.
  always_comb begin
    cfg_valid_s = (int'(cfg_pin) < NUM_PINS) && (int'(cfg_core) < NUM_CORES);
    if (cfg_valid_s) begin
      cur_core_s = pin_core_r[cfg_pin];
    end else begin
      cur_core_s = '0;
    end
  end

  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    pin_next_s   = pin_r;
    core_next_s  = core_r;
    case (state_r)
      IDLE: begin
        if (cfg_we && cfg_valid_s && (cfg_core != cur_core_s)) begin
          state_next_s = BREAK;
          cnt_next_s   = CNT_W'(BREAK_CYCLES);
          pin_next_s   = cfg_pin;
          core_next_s  = cfg_core;
        end else begin
          state_next_s = IDLE;
        end
      end
      BREAK: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = COMMIT;
        end else begin
          cnt_next_s = cnt_r - CNT_W'(1);
        end
      end
      COMMIT:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // On the commit edge the pad already follows the new owner, so the masked
  // window is exactly the BREAK and COMMIT cycles.
  always_comb begin
    gpio_output_next_s = '0;
    gpio_drive_next_s  = '0;
    sel_s              = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      if ((state_r == COMMIT) && (pin_r == PIN_W'(p))) begin
        sel_s = core_r;
      end else begin
        sel_s = pin_core_r[p];
      end
      gpio_output_next_s[p] = out_next_s[sel_s][p];
      if ((state_next_s != IDLE) && (pin_next_s == PIN_W'(p))) begin
        gpio_drive_next_s[p] = 1'b0;
      end else begin
        gpio_drive_next_s[p] = dir_next_s[sel_s][p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      pin_r         <= '0;
      core_r        <= '0;
      pin_core_r    <= '0;
      cfg_ready_r   <= 1'b1;
      gpio_output_r <= '0;
      gpio_drive_r  <= '0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      pin_r         <= pin_next_s;
      core_r        <= core_next_s;
      cfg_ready_r   <= (state_next_s == IDLE);
      gpio_output_r <= gpio_output_next_s;
      gpio_drive_r  <= gpio_drive_next_s;
      if (state_r == COMMIT) begin
        pin_core_r[pin_r] <= core_r;
      end else begin
        pin_core_r <= pin_core_r;
      end
    end
  end

  assign cfg_ready   = cfg_ready_r;
  assign pin_core    = pin_core_r;
  assign gpio_output = gpio_output_r;
  assign gpio_drive  = gpio_drive_r;

endmodule

// File: doc/pin_output_arbiter.md
Name: pin_output_arbiter

Overview:
Parametrised, registered successor to the combinational pin output arbitration stage. Each core's FSMs write pin values and directions through per-pin write strobes, and those values are held in per-core latches. The block then routes each pin's latched value and direction from its assigned core to the GPIO pads. Per-pin core assignment is runtime-configurable, with break-before-make: the pin is undriven for a programmable gap before it changes owner.

Parameters:
NUM_PINS, 32, number of GPIO pins
NUM_CORES, 4, number of PIO cores
NUM_FSMS, 4, state machines per core
BREAK_CYCLES, 1, cycles of forced drive=0 on reassignment (>=1)
SEL_W, $clog2(NUM_CORES), core-select width (derived)
PIN_W, $clog2(NUM_PINS), pin-index width (derived)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
fsm_out_we  in  NUM_CORES*NUM_FSMS*NUM_PINS  per core/fsm/pin output-value write strobe, index ((c*NUM_FSMS)+f)*NUM_PINS+p
fsm_out_val  in  NUM_CORES*NUM_FSMS*NUM_PINS  output value, same indexing
fsm_dir_we  in  NUM_CORES*NUM_FSMS*NUM_PINS  direction write strobe, same indexing
fsm_dir_val  in  NUM_CORES*NUM_FSMS*NUM_PINS  direction value (1 = drive), same indexing
cfg_we  in  1  request pin reassignment
cfg_pin  in  PIN_W  pin to reassign
cfg_core  in  SEL_W  new owning core
cfg_ready  out  1  reassignment request accepted this cycle when high
pin_core  out  NUM_PINS*SEL_W  current core assignment per pin
gpio_output  out  NUM_PINS  registered pad output value
gpio_drive  out  NUM_PINS  registered pad output enable

Behaviour:
- Reset (async, rst=1): all latches 0; pin_core all 0; gpio_output=0; gpio_drive=0; state IDLE; cfg_ready=1. Assert reset during BREAK: aborts the reassignment; the pin ends on core 0.
- Latches:
  - out_latch[c][p] and dir_latch[c][p] update at each clk edge.
  - Per core/pin, the lowest-index f with fsm_out_we set loads fsm_out_val; the same rule applies independently to the dir strobes.
  - No strobe: the latch holds its value.
- Core priority:
  - Cores are independent; there is no priority between cores.
  - Only the owning core reaches the pad.
  - All cores' latches keep updating, including non-owning cores.
- Output path:
  - gpio_output[p] and gpio_drive[p] are registered from the next-state latches of core pin_core[p].
  - A strobe sampled at edge E is visible on the pads after edge E (1-cycle latency).
  - If p ≠ cfg_pin, during BREAK or otherwise, gpio_drive[p] is unaffected.
- Reassignment FSM (one request at a time):
  - IDLE: cfg_ready=1. On cfg_we:
    - If cfg_core == pin_core[cfg_pin]: no-op, stay IDLE.
    - Otherwise capture pin and core, load cnt=BREAK_CYCLES, go to BREAK.
  - BREAK: cfg_ready=0. gpio_drive[pin]=0; gpio_output[pin] continues to follow the old core. cnt decrements each cycle; at cnt==1 go to COMMIT.
  - COMMIT: cfg_ready=0. pin_core[pin] is updated at this edge. gpio_drive[pin] stays 0 this cycle. Go to IDLE.
  - Pad after COMMIT: from the next edge, the pin shows the new core's latches.
  - Total undriven time: BREAK_CYCLES+1 cycles.
- cfg_we while cfg_ready=0: ignored, no queuing.
- cfg_pin >= NUM_PINS: ignored, stay IDLE.
- cfg_core >= NUM_CORES (non-power-of-2 NUM_CORES): ignored.
- Simultaneous events:
  - An FSM write on the pin being reassigned is latched normally in its core, during BREAK or COMMIT.
  - The new owner's write made during COMMIT is visible once IDLE.

Decomposition:
- Shared package pio_pkg:
  - constants NUM_PINS_DEFAULT, NUM_CORES_DEFAULT, NUM_FSMS_DEFAULT
  - reassign state enum {IDLE, BREAK, COMMIT}
  - index helper function fsm_bit_idx(c,f,p)
- One sub-module: core_pin_latch (per core). It holds NUM_PINS out/dir latches plus the lowest-index-FSM priority logic, and is instantiated NUM_CORES times by generate.
- The top level holds the select registers, the reassignment FSM and the output registers.

Test Plan:
1. Reset then idle: after rst deassert, all outputs 0, cfg_ready=1, pin_core all 0; hold 10 cycles -> unchanged.
2. Latching and priority:
   - Core0 fsm1 and fsm2 both strobe pin5 out (vals 0 and 1) plus dir=1 for one cycle -> next cycle gpio_output[5]=0, gpio_drive[5]=1.
   - Strobes removed -> values held for 20 cycles.
3. Non-owner isolation: core2 fsm0 writes pin5 out=1, dir=1 -> gpio pin5 unchanged (owned by core0); pin_core[5] unchanged.
4. Break-before-make, BREAK_CYCLES=2:
   - Setup: core2 latches pin5 out=1, dir=1. Then cfg_we pin5 to core2.
   - Response: cfg_ready low for 3 cycles; gpio_drive[5]=0 for 3 cycles; then gpio_output[5]=1, gpio_drive[5]=1 and pin_core[5]=2.
   - Pin6 is unaffected throughout.
5. Ignored requests:
   - cfg_we during BREAK (pin7 to core1) -> pin_core[7] stays 0.
   - cfg_we pin5 to current owner -> no drive gap, cfg_ready stays 1.
6. Reset mid-BREAK: assert rst during BREAK -> outputs immediately 0, pin_core[5]=0, cfg_ready=1 after deassert.
